pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush/forward controller for the 5-stage core (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall / flush / forward controller for the 5-stage core
// (IF/ID/EX/MEM/WB). It produces the stage-register load enables and bubble
// inserts, and the operand-forwarding mux selects for the R1/R2/R3 inputs of
// ID/EX. It also sequences the data-memory req/ack handshake, freezing the
// pipe on wait states and forcing a release with a sticky error flag if a
// memory access never completes.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int RAW     = 4,   // register-address width
  parameter int MEM_TMO = 15,  // max MWAIT cycles before forced release, 1..255
  parameter int CNT_W   = 16   // width of the stall_cycles counter
) (
  input  logic             clk,
  input  logic             rst,

  // Instruction in ID: source registers and which operands it really reads
  input  logic [RAW-1:0]   i_id_rs1,
  input  logic [RAW-1:0]   i_id_rs2,
  input  logic [RAW-1:0]   i_id_rs3,
  input  logic             i_id_use1,
  input  logic             i_id_use2,
  input  logic             i_id_use3,

  // Destination info of the instructions further down the pipe
  input  logic [RAW-1:0]   i_ex_dest,
  input  logic             i_ex_wreg,
  input  logic             i_ex_rmem,
  input  logic [RAW-1:0]   i_mem_dest,
  input  logic             i_mem_wreg,
  input  logic             i_mem_rmem,
  input  logic             i_mem_wmem,
  input  logic [RAW-1:0]   i_wb_dest,
  input  logic             i_wb_wreg,

  input  logic             i_br_taken,
  input  logic             i_dmem_ack,
  output logic             o_dmem_req,

  // Stage-register control
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_mem_wb_flush,

  // Forwarding selects: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
  output logic [1:0]       o_fwd1,
  output logic [1:0]       o_fwd2,
  output logic [1:0]       o_fwd3,

  output logic [CNT_W-1:0] o_stall_cycles,
  output logic             o_mem_err
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Last MWAIT count value before the access is released by force.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

  state_t           r_state;
  logic [7:0]       r_tmo_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             r_mem_err;

  logic w_mem_acc;
  logic w_tmo_hit;
  logic w_wait;
  logic w_load_use;

  // Forwarding source for one operand: youngest producer wins. A load in EX
  // has no result yet, so it is skipped here and handled by the load-use stall.
  function automatic logic [1:0] fwd_sel(
    input logic [RAW-1:0] rs,
    input logic           use_n,
    input logic           ex_wreg,
    input logic           ex_rmem,
    input logic [RAW-1:0] ex_dest,
    input logic           mem_wreg,
    input logic [RAW-1:0] mem_dest,
    input logic           wb_wreg,
    input logic [RAW-1:0] wb_dest
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_n) begin
      if (ex_wreg && !ex_rmem && ex_dest == rs)
        sel = FWD_EX;
      else if (mem_wreg && mem_dest == rs)
        sel = FWD_MEM;
      else if (wb_wreg && wb_dest == rs)
        sel = FWD_WB;
    end
    return sel;
  endfunction

  assign w_mem_acc = i_mem_rmem | i_mem_wmem;
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

  // A wait cycle freezes everything upstream of WB. The first wait cycle is
  // the RUN cycle in which the access starts without an ack.
  assign w_wait = ((r_state == RUN)   && w_mem_acc && !i_dmem_ack) ||
                  ((r_state == MWAIT) && !i_dmem_ack && !w_tmo_hit);

  // Load in EX whose destination feeds an operand the ID instruction reads.
  assign w_load_use = i_ex_rmem && i_ex_wreg &&
                      ((i_id_use1 && i_ex_dest == i_id_rs1) ||
                       (i_id_use2 && i_ex_dest == i_id_rs2) ||
                       (i_id_use3 && i_ex_dest == i_id_rs3));

  // Stage enables, bubbles and memory request; everything held inactive in reset.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_id_ex_en     = 1'b0;
    o_ex_mem_en    = 1'b0;
    o_mem_wb_en    = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_mem_wb_flush = 1'b0;
    o_dmem_req     = 1'b0;

    if (!rst) begin
      o_dmem_req = ((r_state == RUN) && w_mem_acc) || (r_state == MWAIT);

      if (w_wait) begin
        // Only WB advances, and it takes a bubble; a branch in EX stays frozen
        // and is acted on once the memory access releases.
        o_mem_wb_en    = 1'b1;
        o_mem_wb_flush = 1'b1;
      end else if (i_br_taken) begin
        // Squash IF/ID and ID/EX; the squashed ID instruction needs no stall.
        o_pc_en       = 1'b1;
        o_if_id_en    = 1'b1;
        o_id_ex_en    = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        // Hold IF and ID for one cycle and send a bubble into EX.
        o_id_ex_en    = 1'b1;
        o_id_ex_flush = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
      end else begin
        o_pc_en     = 1'b1;
        o_if_id_en  = 1'b1;
        o_id_ex_en  = 1'b1;
        o_ex_mem_en = 1'b1;
        o_mem_wb_en = 1'b1;
      end
    end
  end

  // Forwarding selects track the current stage contents, including during stalls.
  always_comb begin
    o_fwd1 = FWD_RF;
    o_fwd2 = FWD_RF;
    o_fwd3 = FWD_RF;
    if (!rst) begin
      o_fwd1 = fwd_sel(i_id_rs1, i_id_use1, i_ex_wreg, i_ex_rmem, i_ex_dest,
                       i_mem_wreg, i_mem_dest, i_wb_wreg, i_wb_dest);
      o_fwd2 = fwd_sel(i_id_rs2, i_id_use2, i_ex_wreg, i_ex_rmem, i_ex_dest,
                       i_mem_wreg, i_mem_dest, i_wb_wreg, i_wb_dest);
      o_fwd3 = fwd_sel(i_id_rs3, i_id_use3, i_ex_wreg, i_ex_rmem, i_ex_dest,
                       i_mem_wreg, i_mem_dest, i_wb_wreg, i_wb_dest);
    end
  end

  // Memory-handshake FSM with its timeout counter, error flag and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_tmo_cnt      <= 8'd0;
      r_stall_cycles <= '0;
      r_mem_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order in this block.
      if (!o_pc_en && r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + 1'b1;

      case (r_state)
        RUN: begin
          r_tmo_cnt <= 8'd0;
          if (w_mem_acc && !i_dmem_ack)
            r_state <= MWAIT;
        end
        MWAIT: begin
          if (i_dmem_ack || w_tmo_hit) begin
            r_state   <= RUN;
            r_tmo_cnt <= 8'd0;
            // Only a release without an ack is an error.
            if (!i_dmem_ack)
              r_mem_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= RUN;
          r_tmo_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_mem_err      = r_mem_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Each step drives the pipe inputs on the
// falling clock edge, pushes the expected outputs to a scoreboard queue, and
// pops/compares them 1 ns later. A small stall-counter model follows the
// expected pc_en of every clocked cycle. The counter is kept narrow so its
// saturation point is reachable.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RAW     = 4;
  localparam int MEM_TMO = 15;
  localparam int CNT_W   = 5;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush}
  localparam logic [7:0] C_NORM = 8'b11111_000;
  localparam logic [7:0] C_LU   = 8'b00111_010;
  localparam logic [7:0] C_BR   = 8'b11111_110;
  localparam logic [7:0] C_WAIT = 8'b00001_001;
  localparam logic [7:0] C_RST  = 8'b00000_000;

  typedef struct packed {
    logic [7:0]       ctrl;
    logic             req;
    logic [5:0]       fwd;   // {fwd1, fwd2, fwd3}
    logic [CNT_W-1:0] stall;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [RAW-1:0] id_rs1, id_rs2, id_rs3;
  logic           id_use1, id_use2, id_use3;
  logic [RAW-1:0] ex_dest, mem_dest, wb_dest;
  logic           ex_wreg, ex_rmem, mem_wreg, mem_rmem, mem_wmem, wb_wreg;
  logic           br_taken, dmem_ack;

  logic             dmem_req;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]       fwd1, fwd2, fwd3;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_err;

  exp_t  sb_q[$];
  string tag_q[$];

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] exp_stall = '0;
  logic             exp_err   = 1'b0;

  pipe_hazard_ctrl #(
    .RAW     (RAW),
    .MEM_TMO (MEM_TMO),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_rs3       (id_rs3),
    .i_id_use1      (id_use1),
    .i_id_use2      (id_use2),
    .i_id_use3      (id_use3),
    .i_ex_dest      (ex_dest),
    .i_ex_wreg      (ex_wreg),
    .i_ex_rmem      (ex_rmem),
    .i_mem_dest     (mem_dest),
    .i_mem_wreg     (mem_wreg),
    .i_mem_rmem     (mem_rmem),
    .i_mem_wmem     (mem_wmem),
    .i_wb_dest      (wb_dest),
    .i_wb_wreg      (wb_wreg),
    .i_br_taken     (br_taken),
    .i_dmem_ack     (dmem_ack),
    .o_dmem_req     (dmem_req),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_id_ex_en     (id_ex_en),
    .o_ex_mem_en    (ex_mem_en),
    .o_mem_wb_en    (mem_wb_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_flush  (id_ex_flush),
    .o_mem_wb_flush (mem_wb_flush),
    .o_fwd1         (fwd1),
    .o_fwd2         (fwd2),
    .o_fwd3         (fwd3),
    .o_stall_cycles (stall_cycles),
    .o_mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rs3 = '0;
    id_use1 = 1'b0; id_use2 = 1'b0; id_use3 = 1'b0;
    ex_dest = '0; mem_dest = '0; wb_dest = '0;
    ex_wreg = 1'b0; ex_rmem = 1'b0;
    mem_wreg = 1'b0; mem_rmem = 1'b0; mem_wmem = 1'b0;
    wb_wreg = 1'b0;
    br_taken = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic cmp(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
    end
  endtask

  // Push the expectation for the inputs just driven, then pop and compare.
  task automatic check_now(input string tag, input logic [7:0] ctrl,
                           input logic req, input logic [5:0] fwd);
    exp_t  e;
    string t;
    e.ctrl  = ctrl;
    e.req   = req;
    e.fwd   = fwd;
    e.stall = exp_stall;
    e.err   = exp_err;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    cmp(t, "ctrl", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                        if_id_flush, id_ex_flush, mem_wb_flush}), 32'(e.ctrl));
    cmp(t, "dmem_req", 32'(dmem_req), 32'(e.req));
    cmp(t, "fwd", 32'({fwd1, fwd2, fwd3}), 32'(e.fwd));
    cmp(t, "stall_cycles", 32'(stall_cycles), 32'(e.stall));
    cmp(t, "mem_err", 32'(mem_err), 32'(e.err));
  endtask

  // Clock one edge; the counter model advances when that cycle stalled the PC.
  task automatic advance(input logic [7:0] ctrl);
    @(posedge clk);
    if (!rst && !ctrl[7] && exp_stall != '1)
      exp_stall = exp_stall + 1'b1;
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic [7:0] ctrl,
                      input logic req, input logic [5:0] fwd);
    check_now(tag, ctrl, req, fwd);
    advance(ctrl);
  endtask

  initial begin
    clear_inputs();
    #1 rst = 1'b1;
    // Busy inputs under reset must not leak through.
    mem_rmem = 1'b1; ex_wreg = 1'b1; ex_dest = 4'd2;
    id_rs1 = 4'd2; id_use1 = 1'b1; br_taken = 1'b1;
    #1;
    check_now("reset_outputs", C_RST, 1'b0, 6'b00_00_00);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    step("idle", C_NORM, 1'b0, 6'b00_00_00);

    // Load-use on rs1, then the load reaches MEM and is forwarded.
    ex_rmem = 1'b1; ex_wreg = 1'b1; ex_dest = 4'd3;
    id_rs1 = 4'd3; id_use1 = 1'b1;
    step("lu_stall", C_LU, 1'b0, 6'b00_00_00);
    ex_rmem = 1'b0; ex_wreg = 1'b0; ex_dest = 4'd0;
    mem_rmem = 1'b1; mem_wreg = 1'b1; mem_dest = 4'd3; dmem_ack = 1'b1;
    step("lu_fwd_mem", C_NORM, 1'b1, 6'b10_00_00);

    // Load-use through rs3 only; a matching but unused operand does not stall.
    clear_inputs();
    ex_rmem = 1'b1; ex_wreg = 1'b1; ex_dest = 4'd7;
    id_rs2 = 4'd7; id_rs3 = 4'd7; id_use3 = 1'b1;
    step("lu_rs3", C_LU, 1'b0, 6'b00_00_00);
    id_use3 = 1'b0;
    step("lu_unused", C_NORM, 1'b0, 6'b00_00_00);

    // Forwarding priority EX > MEM > WB > regfile.
    clear_inputs();
    ex_wreg = 1'b1; ex_dest = 4'd5;
    mem_wreg = 1'b1; mem_dest = 4'd5;
    wb_wreg = 1'b1; wb_dest = 4'd5;
    id_rs1 = 4'd5; id_rs2 = 4'd5; id_use2 = 1'b1;
    id_rs3 = 4'd6; id_use3 = 1'b1;
    step("fwd_ex", C_NORM, 1'b0, 6'b00_01_00);
    ex_wreg = 1'b0;
    step("fwd_mem", C_NORM, 1'b0, 6'b00_10_00);
    mem_wreg = 1'b0;
    step("fwd_wb", C_NORM, 1'b0, 6'b00_11_00);
    wb_wreg = 1'b0;
    step("fwd_rf", C_NORM, 1'b0, 6'b00_00_00);

    // Register 0 forwards like any other register.
    clear_inputs();
    ex_wreg = 1'b1; ex_dest = 4'd0; id_rs1 = 4'd0; id_use1 = 1'b1;
    wb_wreg = 1'b1; wb_dest = 4'd6; id_rs3 = 4'd6; id_use3 = 1'b1;
    step("fwd_r0", C_NORM, 1'b0, 6'b01_00_11);

    // A load in EX is skipped as a forwarding source; MEM supplies it meanwhile.
    clear_inputs();
    ex_rmem = 1'b1; ex_wreg = 1'b1; ex_dest = 4'd5;
    mem_wreg = 1'b1; mem_dest = 4'd5;
    id_rs2 = 4'd5; id_use2 = 1'b1;
    step("lu_fwd_skip_ex", C_LU, 1'b0, 6'b00_10_00);

    // Three wait cycles then ack; branch ignored while waiting, honoured on release.
    clear_inputs();
    mem_rmem = 1'b1; mem_wreg = 1'b1; mem_dest = 4'd9;
    id_rs1 = 4'd9; id_use1 = 1'b1;
    step("wait_run", C_WAIT, 1'b1, 6'b10_00_00);
    step("wait_mw1", C_WAIT, 1'b1, 6'b10_00_00);
    br_taken = 1'b1;
    step("wait_mw2_br", C_WAIT, 1'b1, 6'b10_00_00);
    dmem_ack = 1'b1;
    step("mw_release_br", C_BR, 1'b1, 6'b10_00_00);
    clear_inputs();
    step("after_release", C_NORM, 1'b0, 6'b00_00_00);

    // Branch overrides a simultaneous load-use.
    ex_rmem = 1'b1; ex_wreg = 1'b1; ex_dest = 4'd4;
    id_rs2 = 4'd4; id_use2 = 1'b1; br_taken = 1'b1;
    step("br_over_lu", C_BR, 1'b0, 6'b00_00_00);

    // Store that is never acked: 15 wait cycles, forced release, sticky error.
    clear_inputs();
    mem_wmem = 1'b1;
    step("tmo_run_wait", C_WAIT, 1'b1, 6'b00_00_00);
    for (int i = 0; i < MEM_TMO - 1; i++)
      step("tmo_wait", C_WAIT, 1'b1, 6'b00_00_00);
    step("tmo_release", C_NORM, 1'b1, 6'b00_00_00);
    exp_err = 1'b1;
    mem_wmem = 1'b0; mem_rmem = 1'b1; dmem_ack = 1'b1;
    step("post_tmo_access", C_NORM, 1'b1, 6'b00_00_00);
    dmem_ack = 1'b0;
    step("post_tmo_wait", C_WAIT, 1'b1, 6'b00_00_00);
    dmem_ack = 1'b1;
    step("post_tmo_ack", C_NORM, 1'b1, 6'b00_00_00);

    // Reset in the middle of MWAIT takes effect without a clock edge.
    clear_inputs();
    mem_rmem = 1'b1;
    step("pre_rst_run_wait", C_WAIT, 1'b1, 6'b00_00_00);
    check_now("pre_rst_mwait", C_WAIT, 1'b1, 6'b00_00_00);
    rst = 1'b1;
    exp_stall = '0;
    exp_err   = 1'b0;
    check_now("rst_async", C_RST, 1'b0, 6'b00_00_00);
    advance(C_RST);
    rst = 1'b0;
    clear_inputs();
    step("post_rst_run", C_NORM, 1'b0, 6'b00_00_00);

    // Hold a load-use long enough to saturate the stall counter.
    ex_rmem = 1'b1; ex_wreg = 1'b1; ex_dest = 4'd1;
    id_rs1 = 4'd1; id_use1 = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 2; i++)
      step("sat_lu", C_LU, 1'b0, 6'b00_00_00);
    clear_inputs();
    step("sat_hold", C_NORM, 1'b0, 6'b00_00_00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
